// File: rtl/aes_i2c_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_i2c_pkg
// Brief    : Shared encodings for the I2C-driven AES-128 sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package aes_i2c_pkg;

  localparam int N_BYTES = 33;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_SHORT   = 2'b01;
  localparam logic [1:0] ERR_BAD     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ARMED  = 3'd2,
    ST_LAUNCH = 3'd3,
    ST_RUN    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  // Only the two defined mode bytes are legal; any other upper bit set is rejected.
  function automatic logic mode_ok(input logic [7:0] mode_byte);
    return (mode_byte == {7'd0, MODE_ENC}) || (mode_byte == {7'd0, MODE_DEC});
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_frame_assembler.sv
`default_nettype none
// ============================================================================
// Module   : aes_frame_assembler
// Brief    : Byte counter and text/key/mode store for one received frame.
// Revision : 1.0 - initial release
// ============================================================================
module aes_frame_assembler #(
  parameter int BLK_W   = 128,
  parameter int N_BYTES = aes_i2c_pkg::N_BYTES,
  parameter int CNT_W   = $clog2(N_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_wr_en,
  input  logic [7:0]       i_wr_byte,
  output logic             o_full,
  output logic             o_fill,
  output logic [BLK_W-1:0] o_text,
  output logic [BLK_W-1:0] o_key,
  output logic [7:0]       o_mode
);

  localparam int LANES = BLK_W / 8;
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_BYTES - 1);
  localparam logic [CNT_W-1:0] C_FULL = CNT_W'(N_BYTES);

  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_text_b [LANES];
  logic [7:0]       r_key_b  [LANES];
  logic [7:0]       r_mode;
  logic             w_store;

  assign w_store = i_wr_en && !i_clear && (r_count < C_FULL);
  assign o_fill  = w_store && (r_count == C_LAST);
  assign o_full  = (r_count == C_FULL);
  assign o_mode  = r_mode;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (w_store) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  // Byte k of the frame lands in lane k (text) or lane k-LANES (key); lane 0 is the MSB.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_text_b[i] <= '0;
        r_key_b[i]  <= '0;
      end
      r_mode <= '0;
    end else if (w_store) begin
      for (int i = 0; i < LANES; i++) begin
        if (r_count == CNT_W'(i))         r_text_b[i] <= i_wr_byte;
        if (r_count == CNT_W'(LANES + i)) r_key_b[i]  <= i_wr_byte;
      end
      if (r_count == CNT_W'(2 * LANES)) r_mode <= i_wr_byte;
    end
  end

  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_pack
      assign o_text[BLK_W-1-8*g -: 8] = r_text_b[g];
      assign o_key[BLK_W-1-8*g -: 8]  = r_key_b[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/aes_i2c_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : aes_i2c_sequencer
// Brief    : Collects a text/key/mode frame from the I2C slave, runs one AES op.
// Revision : 1.0 - initial release
// ============================================================================
module aes_i2c_sequencer #(
  parameter int BLK_W       = 128,
  parameter int N_BYTES     = 33,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_start,
  input  logic             rx_valid,
  input  logic [7:0]       rx_byte,
  input  logic             rx_stop,
  output logic             rx_ack,
  output logic             aes_start,
  output logic             aes_mode,
  output logic [BLK_W-1:0] aes_text,
  output logic [BLK_W-1:0] aes_key,
  input  logic             aes_done,
  input  logic [BLK_W-1:0] aes_result,
  output logic [BLK_W-1:0] result,
  output logic             done,
  output logic             busy,
  output logic [1:0]       err
);

  import aes_i2c_pkg::*;

  localparam int WD_W = $clog2(TIMEOUT_CYC);
  localparam logic [WD_W-1:0] C_WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_err;
  logic [1:0]       w_err_nxt;
  logic [BLK_W-1:0] r_result;
  logic [WD_W-1:0]  r_wdog;
  logic [7:0]       w_mode_byte;
  logic [7:0]       w_mode_now;
  logic             w_start_ok;
  logic             w_wr_en;
  logic             w_full;
  logic             w_fill;
  logic             w_full_now;

  assign w_start_ok = rx_start &&
                      (r_state inside {ST_IDLE, ST_LOAD, ST_ARMED, ST_DONE});
  assign w_wr_en    = (r_state == ST_LOAD) && rx_valid;

  aes_frame_assembler #(
    .BLK_W   (BLK_W),
    .N_BYTES (N_BYTES)
  ) u_frame (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_start_ok),
    .i_wr_en   (w_wr_en),
    .i_wr_byte (rx_byte),
    .o_full    (w_full),
    .o_fill    (w_fill),
    .o_text    (aes_text),
    .o_key     (aes_key),
    .o_mode    (w_mode_byte)
  );

  // A byte arriving together with STOP must be counted before STOP is judged.
  assign w_full_now = w_full || w_fill;
  assign w_mode_now = w_fill ? rx_byte : w_mode_byte;

  always_comb begin
    w_state_nxt = r_state;
    w_err_nxt   = r_err;
    case (r_state)
      ST_IDLE: begin
        if (rx_start) begin
          w_state_nxt = ST_LOAD;
          w_err_nxt   = ERR_NONE;
        end
      end
      ST_LOAD: begin
        if (rx_start) begin
          w_state_nxt = ST_LOAD;
        end else if (w_full_now) begin
          if (mode_ok(w_mode_now)) begin
            w_state_nxt = rx_stop ? ST_LAUNCH : ST_ARMED;
          end else begin
            w_err_nxt = ERR_BAD;
            if (rx_stop) w_state_nxt = ST_IDLE;
          end
        end else if (rx_stop) begin
          w_err_nxt   = ERR_SHORT;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (rx_start)     w_state_nxt = ST_LOAD;
        else if (rx_stop) w_state_nxt = ST_LAUNCH;
      end
      ST_LAUNCH: w_state_nxt = ST_RUN;
      ST_RUN: begin
        if (aes_done) begin
          w_state_nxt = ST_DONE;
        end else if (r_wdog == C_WD_LAST) begin
          w_err_nxt   = ERR_TIMEOUT;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_DONE: begin
        if (rx_start) begin
          w_state_nxt = ST_LOAD;
          w_err_nxt   = ERR_NONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wdog   <= '0;
      r_result <= '0;
    end else begin
      if (r_state == ST_LAUNCH)   r_wdog <= '0;
      else if (r_state == ST_RUN) r_wdog <= r_wdog + WD_W'(1);
      if ((r_state == ST_RUN) && aes_done) r_result <= aes_result;
    end
  end

  assign rx_ack    = (r_state == ST_LOAD) && !w_full;
  assign aes_start = (r_state == ST_LAUNCH);
  assign aes_mode  = w_mode_byte[0];
  assign busy      = r_state inside {ST_ARMED, ST_LAUNCH, ST_RUN};
  assign done      = (r_state == ST_DONE);
  assign result    = r_result;
  assign err       = r_err;

endmodule
`default_nettype wire
